// File: rtl/region_scan_controller.sv
// Region scan controller: sweeps the shared colour tracker across the four
// screen regions, builds a per-sweep hit mask and debounces it into gestures.
module region_scan_controller #(
  parameter int unsigned FRAMES_PER_REGION = 1,
  parameter int unsigned STABLE_SWEEPS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       regiao_detectada,
  output logic [1:0] region,
  output logic [3:0] hit_mask,
  output logic       gesture_valid,
  output logic [1:0] gesture_region,
  output logic       ambiguous,
  output logic [1:0] state
);
  localparam int unsigned DW = (FRAMES_PER_REGION > 1) ? $clog2(FRAMES_PER_REGION) : 1;
  localparam int unsigned SW = $clog2(STABLE_SWEEPS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_REGION - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SWEEPS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    region_q, region_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [1:0]    cand_q, cand_d;
  logic          latch_q, latch_d;
  logic [3:0]    sweep_q, sweep_d;
  logic [3:0]    hit_mask_q, hit_mask_d;
  logic          gv_q, gv_d;
  logic [1:0]    gr_q, gr_d;
  logic          amb_q, amb_d;

  logic          hit;
  logic [3:0]    step_mask;
  logic          mask_onehot;
  logic [1:0]    mask_idx;
  logic [SW-1:0] stable_inc;
  logic [SW-1:0] stable_new;

  // Current frame's hit uses the latch before any same-cycle frame_start clear.
  assign hit         = latch_q | regiao_detectada;
  assign step_mask   = sweep_q | (4'(hit) << region_q);
  assign mask_onehot = (step_mask != '0) && ((step_mask & (step_mask - 4'd1)) == '0);
  assign stable_inc  = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
  assign stable_new  = (mask_idx == cand_q) ? stable_inc : SW'(1);

  always_comb begin
    mask_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (step_mask[i]) mask_idx = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    dwell_d    = dwell_q;
    stable_d   = stable_q;
    cand_d     = cand_q;
    latch_d    = latch_q;
    sweep_d    = sweep_q;
    hit_mask_d = hit_mask_q;
    gv_d       = 1'b0;
    gr_d       = gr_q;
    amb_d      = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      region_d = '0;
      dwell_d  = '0;
      stable_d = '0;
      cand_d   = '0;
      latch_d  = 1'b0;
      sweep_d  = '0;
    end else begin
      if (frame_start)           latch_d = 1'b0;
      else if (regiao_detectada) latch_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_start) state_d = SCAN;
        end
        SCAN, LOCKED: begin
          if (frame_end) begin
            // Every frame of a dwell contributes, so a hit early in the dwell is kept.
            sweep_d = step_mask;
            if (dwell_q < DWELL_LAST) begin
              dwell_d = dwell_q + DW'(1);
            end else begin
              dwell_d  = '0;
              region_d = region_q + 2'd1;
              if (region_q == 2'd3) begin
                sweep_d    = '0;
                hit_mask_d = step_mask;
                if (state_q == LOCKED) begin
                  state_d = (step_mask == '0) ? SCAN : LOCKED;
                end else begin
                  // Decision is registered on entry so the pulses coincide with DECIDE.
                  state_d = DECIDE;
                  if (step_mask == '0) begin
                    stable_d = '0;
                  end else if (!mask_onehot) begin
                    amb_d    = 1'b1;
                    stable_d = '0;
                  end else begin
                    cand_d = mask_idx;
                    if (stable_new == STABLE_MAX) begin
                      gv_d     = 1'b1;
                      gr_d     = mask_idx;
                      stable_d = '0;
                    end else begin
                      stable_d = stable_new;
                    end
                  end
                end
              end
            end
          end
        end
        DECIDE: begin
          state_d = gv_q ? LOCKED : SCAN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      region_q   <= '0;
      dwell_q    <= '0;
      stable_q   <= '0;
      cand_q     <= '0;
      latch_q    <= 1'b0;
      sweep_q    <= '0;
      hit_mask_q <= '0;
      gv_q       <= 1'b0;
      gr_q       <= '0;
      amb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      dwell_q    <= dwell_d;
      stable_q   <= stable_d;
      cand_q     <= cand_d;
      latch_q    <= latch_d;
      sweep_q    <= sweep_d;
      hit_mask_q <= hit_mask_d;
      gv_q       <= gv_d;
      gr_q       <= gr_d;
      amb_q      <= amb_d;
    end
  end

  assign region         = region_q;
  assign hit_mask       = hit_mask_q;
  assign gesture_valid  = gv_q;
  assign gesture_region = gr_q;
  assign ambiguous      = amb_q;
  assign state          = state_q;
endmodule
